multicycle_exec_core: RTL and testbench
=======================================

// Module: multicycle_exec_core
//
// PURPOSE
//  Parametrised multi-cycle execution core: register file, operand setup, ALU,
//  iterative multiplier/divider, writeback, with start/busy/done handshake.
//  Takes pre-decoded instruction fields from the instruction decoder.
//  Replaces the fixed-width core whose mul/div results were tied to zero.
//
// PARAMETERS
//  DATA_WIDTH     32  operand/register width, >= 4
//  REG_COUNT      32  number of architectural registers; reg 0 reads as 0
//  REGADDR_WIDTH  5   register address width, = clog2(REG_COUNT)
//
// PORTS
//  clk              in   1              clock; all state changes on rising edge
//  reset            in   1              synchronous, active-high
//  start            in   1              launch instruction; sampled only in IDLE
//  aLoc             in   REGADDR_WIDTH  source A register
//  bLoc             in   REGADDR_WIDTH  source B register
//  immediateVal     in   DATA_WIDTH     immediate operand
//  immediateSelect  in   1              1: B = immediateVal, 0: B = reg[bLoc]
//  unsignedSelect   in   1              1: unsigned compare/divide
//  subtractEnable   in   1              adder computes A-B
//  resultSelect     in   3              0 add,1 mul,2 div,3 rem,4 gt,5 eq,6 lt,7 zero
//  writeSelect      in   REGADDR_WIDTH  destination register
//  writeEnable      in   1              commit result to writeSelect
//  debugSelect      in   REGADDR_WIDTH  debug read address (combinational)
//  busy             out  1              high in SETUP/EXECUTE/WRITEBACK
//  done             out  1              one-cycle pulse in WRITEBACK
//  result           out  DATA_WIDTH     final result; valid while done=1, held after
//  debugRegOut      out  DATA_WIDTH     reg[debugSelect]
//
// BEHAVIOUR
//  - Reset: state IDLE, all registers 0, busy=0, done=0, result=0; aborts any
//    in-flight op with no register write.
//  - FSM IDLE->SETUP->EXECUTE->WRITEBACK->IDLE. start is ignored unless IDLE.
//  - Edge E0 (IDLE, start=1): all input fields latched; inputs may change after.
//  - SETUP (1 cycle): A=reg[aLoc], B=imm or reg[bLoc] latched at its end edge.
//  - EXECUTE: 1 cycle for codes 0,4-7; DATA_WIDTH cycles for 1-3 (1 bit/cycle).
//  - WRITEBACK (1 cycle): done=1, result driven; reg written at end edge if
//    writeEnable && writeSelect!=0. Writes to reg 0 discarded.
//  - Latency single-cycle ops: done in 3rd cycle after E0, busy low after 4th
//    edge; mul/div: done in (DATA_WIDTH+2)th cycle. Next start accepted in IDLE.
//  - Add/sub modulo 2^DATA_WIDTH, no flags. mul = low DATA_WIDTH bits of A*B.
//  - Compare results zero-extended 0/1; signed unless unsignedSelect.
//  - div/rem truncate toward zero; signed remainder takes sign of dividend.
//  - Divide by zero: quotient all ones, remainder = A.
//  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
//  - Reads in SETUP see the previous instruction's writeback (no bypass needed).
//  - debugRegOut is combinational, reg 0 returns 0.
//
// TESTING (DATA_WIDTH=32)
//  - reset, add imm 5 to r0 -> r1; add imm 7 r1->r2 -> done at cycle 3, r2=12.
//  - r1=0xFFFFFFFF, sub r1-imm 1 unsigned lt vs r0 -> 0; signed lt -> 1.
//  - r1=-7,r2=2: mul->r3=-14 (done cycle 34); div->-3; rem->-1; unsigned div ok.
//  - div by 0: r1=9/r0 -> q=0xFFFFFFFF, rem=9; 0x80000000/-1 -> q=0x80000000, rem 0.
//  - start asserted while busy and writeSelect=0 writes -> ignored, r0 stays 0.
//  - reset at EXECUTE cycle 10 of div -> busy=0, done never pulses, dest reg 0.

Source files
------------

// File: rtl/multicycle_exec_core.sv
// Multi-cycle execution core: register file, operand setup, single-cycle ALU,
// iterative shift-add multiplier and restoring divider, and writeback, with a
// start/busy/done handshake. All instruction fields are captured on the start
// edge, so the caller may change them while the core is busy.
module multicycle_exec_core #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_COUNT     = 32,
  parameter int unsigned REGADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [REGADDR_WIDTH-1:0] aLoc,
  input  logic [REGADDR_WIDTH-1:0] bLoc,
  input  logic [DATA_WIDTH-1:0]    immediateVal,
  input  logic                     immediateSelect,
  input  logic                     unsignedSelect,
  input  logic                     subtractEnable,
  input  logic [2:0]               resultSelect,
  input  logic [REGADDR_WIDTH-1:0] writeSelect,
  input  logic                     writeEnable,
  input  logic [REGADDR_WIDTH-1:0] debugSelect,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [DATA_WIDTH-1:0]    debugRegOut
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, EXECUTE, WRITEBACK} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_MUL, OP_DIV, OP_REM, OP_GT, OP_EQ, OP_LT, OP_ZERO
  } op_t;

  state_t                   state;
  op_t                      op;
  logic [REGADDR_WIDTH-1:0] a_loc, b_loc, write_sel;
  logic [DATA_WIDTH-1:0]    imm;
  logic                     imm_sel, uns_sel, sub_en, write_en;
  logic [DATA_WIDTH-1:0]    regs [REG_COUNT];
  logic [DATA_WIDTH-1:0]    op_a, op_b, acc, work_a, work_b;
  logic [CW-1:0]            count;

  logic [DATA_WIDTH-1:0]    src_a, src_b, mag_a, mag_b;
  logic                     is_div, is_multi, signed_div;
  logic [DATA_WIDTH-1:0]    mul_acc, div_rem, div_quo, quo_fix, rem_fix;
  logic [DATA_WIDTH:0]      div_shift, div_diff;
  logic                     q_bit, q_neg, r_neg, b_zero;
  logic [DATA_WIDTH-1:0]    alu_result, iter_result;

  assign debugRegOut = (debugSelect == '0) ? '0 : regs[debugSelect];

  // Operand fetch and divide magnitude preparation for the SETUP cycle
  always_comb begin
    src_a      = (a_loc == '0) ? '0 : regs[a_loc];
    src_b      = imm_sel ? imm : ((b_loc == '0) ? '0 : regs[b_loc]);
    is_div     = (op == OP_DIV) || (op == OP_REM);
    is_multi   = is_div || (op == OP_MUL);
    signed_div = is_div && !uns_sel;
    mag_a      = (signed_div && src_a[DATA_WIDTH-1]) ? -src_a : src_a;
    mag_b      = (signed_div && src_b[DATA_WIDTH-1]) ? -src_b : src_b;
  end

  // One multiply/divide step plus sign and special-case fixup of the final step.
  // Signed MIN / -1 falls out naturally: |MIN| = 2^(W-1) unsigned, sign stays positive.
  always_comb begin
    mul_acc   = acc + (work_b[0] ? work_a : '0);
    div_shift = {acc, work_a[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, work_b};
    q_bit     = !div_diff[DATA_WIDTH];
    div_rem   = q_bit ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    div_quo   = {work_a[DATA_WIDTH-2:0], q_bit};
    b_zero    = (op_b == '0);
    q_neg     = !uns_sel && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
    r_neg     = !uns_sel && op_a[DATA_WIDTH-1];
    quo_fix   = b_zero ? '1   : (q_neg ? -div_quo : div_quo);
    rem_fix   = b_zero ? op_a : (r_neg ? -div_rem : div_rem);
    case (op)
      OP_MUL:  iter_result = mul_acc;
      OP_DIV:  iter_result = quo_fix;
      default: iter_result = rem_fix;
    endcase
  end

  // Single-cycle ALU on the latched operands
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD: alu_result = sub_en ? (op_a - op_b) : (op_a + op_b);
      OP_GT:  alu_result[0] = uns_sel ? (op_a > op_b) : ($signed(op_a) > $signed(op_b));
      OP_EQ:  alu_result[0] = (op_a == op_b);
      OP_LT:  alu_result[0] = uns_sel ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
      default: alu_result = '0;
    endcase
  end

  // Control FSM with registered busy/done/result and iterative datapath state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      op        <= OP_ADD;
      a_loc     <= '0;
      b_loc     <= '0;
      write_sel <= '0;
      imm       <= '0;
      imm_sel   <= 1'b0;
      uns_sel   <= 1'b0;
      sub_en    <= 1'b0;
      write_en  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      work_a    <= '0;
      work_b    <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op        <= op_t'(resultSelect);
            a_loc     <= aLoc;
            b_loc     <= bLoc;
            imm       <= immediateVal;
            imm_sel   <= immediateSelect;
            uns_sel   <= unsignedSelect;
            sub_en    <= subtractEnable;
            write_sel <= writeSelect;
            write_en  <= writeEnable;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          op_a   <= src_a;
          op_b   <= src_b;
          acc    <= '0;
          count  <= '0;
          work_a <= is_div ? mag_a : src_a;
          work_b <= is_div ? mag_b : src_b;
          state  <= EXECUTE;
        end
        EXECUTE: begin
          if (is_multi) begin
            count <= count + 1'b1;
            if (op == OP_MUL) begin
              acc    <= mul_acc;
              work_a <= work_a << 1;
              work_b <= work_b >> 1;
            end else begin
              acc    <= div_rem;
              work_a <= div_quo;
            end
            if (count == LAST_STEP) begin
              result <= iter_result;
              done   <= 1'b1;
              state  <= WRITEBACK;
            end
          end else begin
            result <= alu_result;
            done   <= 1'b1;
            state  <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file: cleared on reset, written at the end of WRITEBACK; reg 0 never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (state == WRITEBACK && write_en && write_sel != '0) begin
      regs[write_sel] <= result;
    end
  end

endmodule

// File: tb/tb_multicycle_exec_core.sv
// Directed bench for multicycle_exec_core (DATA_WIDTH=32): a table of
// instructions with hand-computed results/latencies, followed by hand-written
// sequences for start-while-busy and reset during a divide.
module tb_multicycle_exec_core;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    aLoc, bLoc, writeSelect, debugSelect;
  logic [W-1:0]  immediateVal;
  logic          immediateSelect, unsignedSelect, subtractEnable, writeEnable;
  logic [2:0]    resultSelect;
  logic          busy, done;
  logic [W-1:0]  result, debugRegOut;

  int errors = 0;
  int checks = 0;

  multicycle_exec_core #(.DATA_WIDTH(32), .REG_COUNT(32), .REGADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .aLoc(aLoc), .bLoc(bLoc),
    .immediateVal(immediateVal), .immediateSelect(immediateSelect),
    .unsignedSelect(unsignedSelect), .subtractEnable(subtractEnable),
    .resultSelect(resultSelect), .writeSelect(writeSelect), .writeEnable(writeEnable),
    .debugSelect(debugSelect), .busy(busy), .done(done), .result(result),
    .debugRegOut(debugRegOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   rs;
    logic [4:0]   a;
    logic [4:0]   b;
    logic [W-1:0] imm;
    logic         isel;
    logic         uns;
    logic         sub;
    logic         we;
    logic [4:0]   ws;
    logic [W-1:0] exp_res;
    logic [W-1:0] exp_reg;
    int           cyc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [2:0] rs, input logic [4:0] a, input logic [4:0] b,
                              input logic [W-1:0] imm, input logic isel, input logic uns,
                              input logic sub, input logic we, input logic [4:0] ws,
                              input logic [W-1:0] exp_res, input logic [W-1:0] exp_reg,
                              input int cyc);
    vec_t t;
    t.rs = rs; t.a = a; t.b = b; t.imm = imm; t.isel = isel; t.uns = uns; t.sub = sub;
    t.we = we; t.ws = ws; t.exp_res = exp_res; t.exp_reg = exp_reg; t.cyc = cyc;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [W-1:0] v);
    debugSelect = r;
    #1;
    v = debugRegOut;
  endtask

  task automatic drive(input vec_t t);
    resultSelect = t.rs; aLoc = t.a; bLoc = t.b; immediateVal = t.imm;
    immediateSelect = t.isel; unsignedSelect = t.uns; subtractEnable = t.sub;
    writeEnable = t.we; writeSelect = t.ws;
  endtask

  task automatic scramble();
    resultSelect = 3'($urandom); aLoc = 5'($urandom); bLoc = 5'($urandom);
    immediateVal = $urandom; immediateSelect = 1'($urandom); unsignedSelect = 1'($urandom);
    subtractEnable = 1'($urandom); writeEnable = 1'($urandom); writeSelect = 5'($urandom);
  endtask

  // Launch one instruction and wait (bounded) for done; cyc counts cycles after E0
  task automatic run_op(input vec_t t, output logic [W-1:0] res, output int cyc);
    @(negedge clk);
    drive(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    res = result;
  endtask

  localparam logic [2:0] ADD = 3'd0, MUL = 3'd1, DIV = 3'd2, REM = 3'd3,
                         GT = 3'd4, EQ = 3'd5, LT = 3'd6, ZERO = 3'd7;

  initial begin
    logic [W-1:0] r, v;
    int           c, pulses;
    vec_t         t;

    //       rs   a  b  imm          isel uns sub we ws  exp_res      exp_reg      cyc
    vq.push_back(mk(ADD, 0, 0, 32'd5,        1, 0, 0, 1, 1,  32'd5,        32'd5,        3));
    vq.push_back(mk(ADD, 1, 0, 32'd7,        1, 0, 0, 1, 2,  32'd12,       32'd12,       3));
    vq.push_back(mk(ADD, 0, 0, 32'd1,        1, 0, 1, 1, 1,  32'hFFFFFFFF, 32'hFFFFFFFF, 3));
    vq.push_back(mk(ADD, 1, 0, 32'd1,        1, 0, 1, 1, 4,  32'hFFFFFFFE, 32'hFFFFFFFE, 3));
    vq.push_back(mk(LT,  1, 0, 32'd0,        0, 1, 0, 1, 5,  32'd0,        32'd0,        3));
    vq.push_back(mk(LT,  1, 0, 32'd0,        0, 0, 0, 1, 5,  32'd1,        32'd1,        3));
    vq.push_back(mk(GT,  1, 2, 32'd0,        0, 0, 0, 1, 5,  32'd0,        32'd0,        3));
    vq.push_back(mk(GT,  1, 2, 32'd0,        0, 1, 0, 1, 5,  32'd1,        32'd1,        3));
    vq.push_back(mk(EQ,  2, 0, 32'd12,       1, 0, 0, 1, 6,  32'd1,        32'd1,        3));
    vq.push_back(mk(ADD, 0, 0, 32'd7,        1, 0, 1, 1, 1,  32'hFFFFFFF9, 32'hFFFFFFF9, 3));
    vq.push_back(mk(ADD, 0, 0, 32'd2,        1, 0, 0, 1, 2,  32'd2,        32'd2,        3));
    vq.push_back(mk(MUL, 1, 2, 32'd0,        0, 0, 0, 1, 3,  32'hFFFFFFF2, 32'hFFFFFFF2, 34));
    vq.push_back(mk(DIV, 1, 2, 32'd0,        0, 0, 0, 1, 6,  32'hFFFFFFFD, 32'hFFFFFFFD, 34));
    vq.push_back(mk(REM, 1, 2, 32'd0,        0, 0, 0, 1, 7,  32'hFFFFFFFF, 32'hFFFFFFFF, 34));
    vq.push_back(mk(DIV, 1, 2, 32'd0,        0, 1, 0, 1, 8,  32'h7FFFFFFC, 32'h7FFFFFFC, 34));
    vq.push_back(mk(REM, 1, 2, 32'd0,        0, 1, 0, 1, 8,  32'd1,        32'd1,        34));
    vq.push_back(mk(ADD, 0, 0, 32'd9,        1, 0, 0, 1, 1,  32'd9,        32'd9,        3));
    vq.push_back(mk(DIV, 1, 0, 32'd0,        0, 0, 0, 1, 6,  32'hFFFFFFFF, 32'hFFFFFFFF, 34));
    vq.push_back(mk(REM, 1, 0, 32'd0,        0, 0, 0, 1, 7,  32'd9,        32'd9,        34));
    vq.push_back(mk(DIV, 3, 0, 32'd0,        0, 0, 0, 1, 6,  32'hFFFFFFFF, 32'hFFFFFFFF, 34));
    vq.push_back(mk(REM, 3, 0, 32'd0,        0, 0, 0, 1, 7,  32'hFFFFFFF2, 32'hFFFFFFF2, 34));
    vq.push_back(mk(ADD, 0, 0, 32'h80000000, 1, 0, 0, 1, 8,  32'h80000000, 32'h80000000, 3));
    vq.push_back(mk(ADD, 0, 0, 32'd1,        1, 0, 1, 1, 9,  32'hFFFFFFFF, 32'hFFFFFFFF, 3));
    vq.push_back(mk(DIV, 8, 9, 32'd0,        0, 0, 0, 1, 10, 32'h80000000, 32'h80000000, 34));
    vq.push_back(mk(REM, 8, 9, 32'd0,        0, 0, 0, 1, 11, 32'd0,        32'd0,        34));
    vq.push_back(mk(MUL, 8, 0, 32'd3,        1, 0, 0, 1, 12, 32'h80000000, 32'h80000000, 34));
    vq.push_back(mk(ADD, 0, 0, 32'd55,       1, 0, 0, 1, 0,  32'd55,       32'd0,        3));
    vq.push_back(mk(ADD, 0, 0, 32'd99,       1, 0, 0, 0, 11, 32'd99,       32'd0,        3));
    vq.push_back(mk(ZERO,2, 0, 32'd0,        0, 0, 0, 1, 12, 32'd0,        32'd0,        3));
    vq.push_back(mk(GT,  2, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 13, 32'd1,        32'd1,        3));
    vq.push_back(mk(LT,  8, 9, 32'd0,        0, 0, 0, 1, 13, 32'd1,        32'd1,        3));
    vq.push_back(mk(GT,  8, 9, 32'd0,        0, 1, 0, 1, 13, 32'd0,        32'd0,        3));
    vq.push_back(mk(ADD, 2, 0, 32'd1,        1, 0, 1, 1, 13, 32'd1,        32'd1,        3));

    reset = 1'b1; start = 1'b0; debugSelect = '0;
    scramble();
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    read_reg(5'd1, v);
    check("reset r1", v, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      run_op(t, r, c);
      check($sformatf("v%0d result", i), r, t.exp_res);
      check($sformatf("v%0d latency", i), 32'(c), 32'(t.cyc));
      @(negedge clk);
      check($sformatf("v%0d done pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d busy idle", i), 32'(busy), 32'd0);
      read_reg(t.ws, v);
      check($sformatf("v%0d dest reg", i), v, t.exp_reg);
    end

    // start held high while a multiply is running must not launch a second op
    t = mk(MUL, 1, 2, 32'd0, 0, 0, 0, 1, 14, 32'd18, 32'd18, 34);
    @(negedge clk);
    drive(t);
    start = 1'b1;
    @(negedge clk);
    c = 1;
    resultSelect = ADD; aLoc = 5'd0; immediateVal = 32'd77; immediateSelect = 1'b1;
    subtractEnable = 1'b0; writeSelect = 5'd15; writeEnable = 1'b1;
    while (done !== 1'b1 && c < 200) begin
      if (c == 30) start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("busy-start result", result, 32'd18);
    check("busy-start latency", 32'(c), 32'd34);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("busy-start extra done", 32'(pulses), 32'd0);
    check("busy-start busy", 32'(busy), 32'd0);
    read_reg(5'd15, v);
    check("busy-start r15", v, 32'd0);
    read_reg(5'd14, v);
    check("busy-start r14", v, 32'd18);
    read_reg(5'd0, v);
    check("busy-start r0", v, 32'd0);

    // reset during EXECUTE cycle 10 of a divide aborts without writeback
    t = mk(DIV, 1, 2, 32'd0, 0, 0, 0, 1, 15, 32'd0, 32'd0, 34);
    @(negedge clk);
    drive(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort done pulses", 32'(pulses), 32'd0);
    read_reg(5'd15, v);
    check("abort r15", v, 32'd0);
    read_reg(5'd1, v);
    check("abort r1 cleared", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
